serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor built around a single B-bit full-adder slice that is reused over multiple clock cycles. It is the sequential successor to the combinational full-adder cell: it trades latency for area and adds subtract mode, carry/overflow flags and a start/done handshake. It sits between operand registers and any consumer that can tolerate multi-cycle arithmetic.

---
 rtl/serial_addsub.sv | 136 +++++++++++++
 tb/tb_serial_addsub.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one SLICE-bit ripple slice reused over WIDTH/SLICE cycles,
// with start/done handshake and registered carry/overflow flags.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int K  = WIDTH / SLICE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SLICE-1:0]       slice_sum;
  logic                   slice_cout;
  logic                   slice_cin_top;
  logic                   rip_c;
  logic [WIDTH+SLICE-1:0] res_cat;

  // Ripple across the slice; slice_cin_top keeps the carry into the slice's top bit,
  // which on the last cycle is the carry into the result MSB.
  always_comb begin
    rip_c         = carry_q;
    slice_cin_top = carry_q;
    slice_sum     = '0;
    for (int unsigned i = 0; i < SLICE; i++) begin
      slice_cin_top = rip_c;
      slice_sum[i]  = a_q[i] ^ b_q[i] ^ rip_c;
      rip_c         = (a_q[i] & b_q[i]) | (rip_c & (a_q[i] ^ b_q[i]));
    end
    slice_cout = rip_c;
    res_cat    = {slice_sum, result_q} >> SLICE;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    count_d  = count_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b ^ {WIDTH{sub}};
          carry_d  = sub;
          count_d  = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d      = a_q >> SLICE;
        b_d      = b_q >> SLICE;
        result_d = res_cat[WIDTH-1:0];
        carry_d  = slice_cout;
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          cout_d  = slice_cout;
          ovf_d   = slice_cin_top ^ slice_cout;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: two instances (SLICE=1 and SLICE=4), expected
// results from plain integer arithmetic, checked by per-instance done monitors.
module tb_serial_addsub;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       o;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i  [2];
  logic       sub_i    [2];
  logic [7:0] a_i      [2];
  logic [7:0] b_i      [2];
  logic       busy_o   [2];
  logic       done_o   [2];
  logic [7:0] result_o [2];
  logic       cout_o   [2];
  logic       ovf_o    [2];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub #(.WIDTH(8), .SLICE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .sub(sub_i[0]), .a(a_i[0]), .b(b_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .result(result_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]));

  serial_addsub #(.WIDTH(8), .SLICE(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .sub(sub_i[1]), .a(a_i[1]), .b(b_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .result(result_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]));

  function automatic int kof(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                 input int due);
    exp_t e;
    int   u, sv;
    if (!s) begin
      u  = int'(a) + int'(b);
      sv = int'($signed(a)) + int'($signed(b));
      e.c = (u > 255);
    end else begin
      u  = int'(a) - int'(b);
      sv = int'($signed(a)) - int'($signed(b));
      e.c = (a >= b);
    end
    e.r   = 8'(u);
    e.o   = (sv > 127) || (sv < -128);
    e.due = due;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done_o[0]) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL s1_unexpected_done actual=1 required=0");
      end else begin
        e0 = q0.pop_front();
        check("s1_result", 32'(result_o[0]), 32'(e0.r));
        check("s1_cout", 32'(cout_o[0]), 32'(e0.c));
        check("s1_ovf", 32'(ovf_o[0]), 32'(e0.o));
        check("s1_done_cycle", cyc, e0.due);
        check("s1_busy_in_done", 32'(busy_o[0]), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done_o[1]) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL s4_unexpected_done actual=1 required=0");
      end else begin
        e1 = q1.pop_front();
        check("s4_result", 32'(result_o[1]), 32'(e1.r));
        check("s4_cout", 32'(cout_o[1]), 32'(e1.c));
        check("s4_ovf", 32'(ovf_o[1]), 32'(e1.o));
        check("s4_done_cycle", cyc, e1.due);
        check("s4_busy_in_done", 32'(busy_o[1]), 0);
      end
    end
  end

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic start_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    a_i[d] = a;
    b_i[d] = b;
    sub_i[d] = s;
    start_i[d] = 1'b1;
    @(posedge clk);
    #1;
    start_i[d] = 1'b0;
    push(d, model(a, b, s, cyc + kof(d)));
  endtask

  task automatic wait_drain(input int d);
    int n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      failures++;
      $display("FAIL drain_timeout_dut%0d actual=%0d required=0", d,
               (d == 0) ? q0.size() : q1.size());
      if (d == 0) q0.delete();
      else        q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_busy", 32'(busy_o[d]), 0);
    check("rst_done", 32'(done_o[d]), 0);
    check("rst_result", 32'(result_o[d]), 0);
    check("rst_cout", 32'(cout_o[d]), 0);
    check("rst_ovf", 32'(ovf_o[d]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d required=0", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0;
    for (int d = 0; d < 2; d++) begin
      start_i[d] = 1'b0;
      sub_i[d] = 1'b0;
      a_i[d] = '0;
      b_i[d] = '0;
    end
    #12;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Add without carry, with busy-width measurement
    start_op(0, 8'd100, 8'd27, 1'b0);
    n = 0;
    @(negedge clk);
    while (busy_o[0] && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("s1_busy_cycles", n, 8);
    wait_drain(0);

    start_op(0, 8'd200, 8'd100, 1'b0); wait_drain(0);
    start_op(0, 8'd5, 8'd7, 1'b1);     wait_drain(0);
    start_op(0, 8'h80, 8'h01, 1'b1);   wait_drain(0);
    start_op(0, 8'd127, 8'd1, 1'b0);   wait_drain(0);
    start_op(1, 8'hFF, 8'h01, 1'b0);   wait_drain(1);

    // Asynchronous reset away from any clock edge: held flags must clear at once
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_s1_result_was_128", 32'(result_o[0]), 0);
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start pulsed mid-RUN with other operands is ignored
    start_op(0, 8'd50, 8'd60, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a_i[0] = 8'd1; b_i[0] = 8'd2; sub_i[0] = 1'b1; start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    wait_drain(0);
    repeat (4) @(negedge clk);

    // start held across DONE: done pulses K+1 apart
    @(negedge clk);
    a_i[0] = 8'd30; b_i[0] = 8'd40; sub_i[0] = 1'b0; start_i[0] = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    q0.push_back(model(8'd30, 8'd40, 1'b0, c0 + 8));
    q0.push_back(model(8'd9, 8'd3, 1'b1, c0 + 17));
    @(negedge clk);
    a_i[0] = 8'd9; b_i[0] = 8'd3; sub_i[0] = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    start_i[0] = 1'b0;
    wait_drain(0);

    // Reset during the third RUN cycle: no done may follow
    @(negedge clk);
    a_i[0] = 8'd10; b_i[0] = 8'd20; sub_i[0] = 1'b0; start_i[0] = 1'b1;
    @(posedge clk);
    #1;
    start_i[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 32'(busy_o[0]), 0);
    check("midrun_rst_done", 32'(done_o[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrun_rst_stays_idle", 32'(busy_o[0]), 0);

    // Randomized operations on both slice widths
    for (int i = 0; i < 60; i++) begin
      int d;
      d = i % 2;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(d, 8'($urandom), 8'($urandom), 1'($urandom));
      wait_drain(d);
    end

    wait_drain(0);
    wait_drain(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
